// File: rtl/vga_sync.sv
// vga_sync: 640x480@60 Hz VGA timing generator.
// Derives a 25 MHz pixel enable from the 50 MHz clock, runs the horizontal and
// vertical scan counters, and drives registered hsync/vsync plus the
// video_on / pix_x / pix_y handshake to the graphics stage.
// Optional feature: define VGA_SYNC_FRAME_TICK_EN to add the f_tick output
// (one clk pulse in the last pixel slot of every frame).
module vga_sync #(
  parameter int unsigned HD       = 640,
  parameter int unsigned HF       = 16,
  parameter int unsigned HB       = 48,
  parameter int unsigned HR       = 96,
  parameter int unsigned VD       = 480,
  parameter int unsigned VF       = 10,
  parameter int unsigned VB       = 33,
  parameter int unsigned VR       = 2,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       p_tick,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y
`ifdef VGA_SYNC_FRAME_TICK_EN
  ,
  output logic       f_tick
`endif
);

  localparam int unsigned CW      = 10;
  localparam int unsigned H_TOTAL = HD + HF + HB + HR;
  localparam int unsigned V_TOTAL = VD + VF + VB + VR;

  // Counters are CW bits wide, so totals beyond 2**CW cannot be represented.
  if (H_TOTAL > 1024) begin : g_h_total_chk
    $error("vga_sync: H_TOTAL exceeds 1024");
  end
  if (V_TOTAL > 1024) begin : g_v_total_chk
    $error("vga_sync: V_TOTAL exceeds 1024");
  end

  localparam logic [CW-1:0] H_MAX    = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_MAX    = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_DISP   = CW'(HD);
  localparam logic [CW-1:0] V_DISP   = CW'(VD);
  localparam logic [CW-1:0] H_SYNC_S = CW'(HD + HF);
  localparam logic [CW-1:0] H_SYNC_E = CW'(HD + HF + HR - 1);
  localparam logic [CW-1:0] V_SYNC_S = CW'(VD + VF);
  localparam logic [CW-1:0] V_SYNC_E = CW'(VD + VF + VR - 1);

  localparam logic SYNC_ACT   = SYNC_POL;
  localparam logic SYNC_INACT = ~SYNC_POL;

  logic          tick_q,  tick_d;
  logic [CW-1:0] h_q,     h_d;
  logic [CW-1:0] v_q,     v_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          h_end;
  logic          v_end;

  // State register: pixel-enable phase, scan counters and sync flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_q  <= 1'b0;
      h_q     <= '0;
      v_q     <= '0;
      hsync_q <= SYNC_INACT;
      vsync_q <= SYNC_INACT;
    end else begin
      tick_q  <= tick_d;
      h_q     <= h_d;
      v_q     <= v_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  // Next state: toggle the pixel enable, step counters on pixel slots, and
  // decode sync from the next counter values so it lines up with pix_x/pix_y.
  always_comb begin
    tick_d  = ~tick_q;
    h_d     = h_q;
    v_d     = v_q;
    h_end   = (h_q == H_MAX);
    v_end   = (v_q == V_MAX);

    if (tick_q) begin
      if (h_end) begin
        h_d = '0;
        if (v_end) begin
          v_d = '0;
        end else begin
          v_d = v_q + CW'(1);
        end
      end else begin
        h_d = h_q + CW'(1);
      end
    end

    hsync_d = ((h_d >= H_SYNC_S) && (h_d <= H_SYNC_E)) ? SYNC_ACT : SYNC_INACT;
    vsync_d = ((v_d >= V_SYNC_S) && (v_d <= V_SYNC_E)) ? SYNC_ACT : SYNC_INACT;
  end

  // Outputs to the graphics stage, taken straight from the registered counters.
  always_comb begin
    p_tick   = tick_q;
    pix_x    = h_q;
    pix_y    = v_q;
    video_on = (h_q < H_DISP) && (v_q < V_DISP);
`ifdef VGA_SYNC_FRAME_TICK_EN
    f_tick   = tick_q && (h_q == H_MAX) && (v_q == V_MAX);
`endif
  end

  assign hsync = hsync_q;
  assign vsync = vsync_q;

endmodule
